// File: rtl/rob_multi_commit.sv
// Reorder buffer: circular entry store with explicit occupancy, NUM_CDB result capture ports,
// in-order retirement of up to COMMIT_W entries per cycle and branch-mispredict flush.
module rob_multi_commit #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned NUM_CDB     = 2,
  parameter int unsigned COMMIT_W    = 2,
  parameter int unsigned FULL_MARGIN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [1:0]                issue_kind,
  input  logic [4:0]                issue_rd,
  input  logic [31:0]               issue_pc,
  input  logic [31:0]               issue_imm,
  input  logic                      issue_predict,
  output logic [TAG_W-1:0]          rob_next_tag,
  output logic [TAG_W-1:0]          rob_top_tag,
  output logic                      rob_full,
  output logic [TAG_W:0]            rob_count,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*32-1:0]     cdb_result,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*5-1:0]     commit_rd,
  output logic [COMMIT_W*TAG_W-1:0] commit_tag,
  output logic [COMMIT_W*32-1:0]    commit_val,
  output logic                      commit_store,
  output logic                      pred_upd_valid,
  output logic [31:0]               pred_upd_pc,
  output logic                      pred_upd_taken,
  output logic                      rollback,
  output logic [31:0]               reset_pc
);

  localparam logic [1:0]     KindReg    = 2'd0;
  localparam logic [1:0]     KindStore  = 2'd1;
  localparam logic [1:0]     KindBranch = 2'd2;
  localparam logic [1:0]     KindRsvd   = 2'd3;
  localparam logic [TAG_W:0] DepthCnt   = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] FullThresh = (TAG_W+1)'(DEPTH - FULL_MARGIN);

  // Pointer / occupancy state
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] ready_q, ready_d;

  // Entry payload
  logic [31:0]      value_q  [DEPTH];
  logic [1:0]       kind_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      alt_pc_q [DEPTH];
  logic [DEPTH-1:0] pred_q;

  // Registered retirement outputs
  logic [COMMIT_W-1:0]       commit_valid_q, commit_valid_d;
  logic [COMMIT_W*5-1:0]     commit_rd_q, commit_rd_d;
  logic [COMMIT_W*TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic [COMMIT_W*32-1:0]    commit_val_q, commit_val_d;
  logic                      commit_store_q, commit_store_d;
  logic                      pred_upd_valid_q, pred_upd_valid_d;
  logic [31:0]               pred_upd_pc_q, pred_upd_pc_d;
  logic                      pred_upd_taken_q, pred_upd_taken_d;
  logic                      rollback_q, rollback_d;
  logic [31:0]               reset_pc_q, reset_pc_d;

  logic [1:0]          issue_kind_n;
  logic                issue_ready;
  logic [31:0]         issue_alt;
  logic                issue_fire;
  logic                flush;
  logic [COMMIT_W-1:0] retire;
  logic [TAG_W-1:0]    slot_idx [COMMIT_W];
  logic [TAG_W:0]      n_retire;
  logic [NUM_CDB-1:0]  cdb_hit;
  logic [TAG_W-1:0]    cdb_tag_k [NUM_CDB];
  logic [TAG_W-1:0]    cdb_off   [NUM_CDB];

  assign issue_kind_n = (issue_kind == KindRsvd) ? KindReg : issue_kind;
  assign issue_ready  = (issue_kind_n != KindBranch) && (issue_rd == 5'd0);
  assign issue_alt    = issue_pc + (issue_predict ? 32'd4 : issue_imm);

  // A pending rollback flushes on the following edge regardless of rdy.
  assign flush = rollback_q;

  // CDB writes only land on tags inside the allocated window [head, head+count).
  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_tag_k[k] = cdb_tag[k*TAG_W +: TAG_W];
      cdb_off[k]   = cdb_tag_k[k] - head_q;
      cdb_hit[k]   = cdb_valid[k] && ({1'b0, cdb_off[k]} < count_q);
    end
  end

  // Younger slots retire only behind an older register-writer, so at most one
  // store/branch retires per cycle and it is the youngest.
  always_comb begin
    for (int s = 0; s < COMMIT_W; s++) begin
      slot_idx[s] = head_q + TAG_W'(s);
    end
    retire    = '0;
    retire[0] = rdy && !rollback_q && (count_q != '0) && ready_q[slot_idx[0]];
    for (int s = 1; s < COMMIT_W; s++) begin
      retire[s] = retire[s-1] && (kind_q[slot_idx[s-1]] == KindReg) &&
                  (count_q > (TAG_W+1)'(s)) && ready_q[slot_idx[s]];
    end
    n_retire = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      n_retire = n_retire + (TAG_W+1)'(retire[s]);
    end
  end

  // A full buffer still accepts an issue when a retirement frees a slot this cycle.
  assign issue_fire = rdy && !flush && issue_valid &&
                      ((count_q < DepthCnt) || (n_retire != '0));

  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    ready_d          = ready_q;
    commit_valid_d   = '0;
    commit_store_d   = 1'b0;
    pred_upd_valid_d = 1'b0;
    rollback_d       = 1'b0;
    commit_rd_d      = commit_rd_q;
    commit_tag_d     = commit_tag_q;
    commit_val_d     = commit_val_q;
    pred_upd_pc_d    = pred_upd_pc_q;
    pred_upd_taken_d = pred_upd_taken_q;
    reset_pc_d       = reset_pc_q;

    if (flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      ready_d      = '0;
      commit_rd_d  = '0;
      commit_tag_d = '0;
      commit_val_d = '0;
    end else if (rdy) begin
      commit_rd_d  = '0;
      commit_tag_d = '0;
      commit_val_d = '0;
      for (int s = 0; s < COMMIT_W; s++) begin
        if (retire[s]) begin
          ready_d[slot_idx[s]]              = 1'b0;
          commit_valid_d[s]                 = 1'b1;
          commit_rd_d[s*5 +: 5]             = rd_q[slot_idx[s]];
          commit_tag_d[s*TAG_W +: TAG_W]    = slot_idx[s];
          commit_val_d[s*32 +: 32]          = value_q[slot_idx[s]];
          case (kind_q[slot_idx[s]])
            KindStore: commit_store_d = 1'b1;
            KindBranch: begin
              pred_upd_valid_d = 1'b1;
              pred_upd_pc_d    = pc_q[slot_idx[s]];
              pred_upd_taken_d = value_q[slot_idx[s]][0];
              if (value_q[slot_idx[s]][0] != pred_q[slot_idx[s]]) begin
                rollback_d = 1'b1;
                reset_pc_d = alt_pc_q[slot_idx[s]];
              end
            end
            default: ;
          endcase
        end
      end
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_hit[k]) begin
          ready_d[cdb_tag_k[k]] = 1'b1;
        end
      end
      if (issue_fire) begin
        ready_d[tail_q] = issue_ready;
        tail_d          = tail_q + TAG_W'(1);
      end
      head_d  = head_q + n_retire[TAG_W-1:0];
      count_d = count_q + (TAG_W+1)'(issue_fire) - n_retire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      ready_q          <= '0;
      commit_valid_q   <= '0;
      commit_rd_q      <= '0;
      commit_tag_q     <= '0;
      commit_val_q     <= '0;
      commit_store_q   <= 1'b0;
      pred_upd_valid_q <= 1'b0;
      pred_upd_pc_q    <= '0;
      pred_upd_taken_q <= 1'b0;
      rollback_q       <= 1'b0;
      reset_pc_q       <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      ready_q          <= ready_d;
      commit_valid_q   <= commit_valid_d;
      commit_rd_q      <= commit_rd_d;
      commit_tag_q     <= commit_tag_d;
      commit_val_q     <= commit_val_d;
      commit_store_q   <= commit_store_d;
      pred_upd_valid_q <= pred_upd_valid_d;
      pred_upd_pc_q    <= pred_upd_pc_d;
      pred_upd_taken_q <= pred_upd_taken_d;
      rollback_q       <= rollback_d;
      reset_pc_q       <= reset_pc_d;
    end
  end

  // Issue writes after CDB so a slot reused at full occupancy takes the new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        value_q[i]  <= '0;
        kind_q[i]   <= KindReg;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        alt_pc_q[i] <= '0;
      end
      pred_q <= '0;
    end else if (rdy && !flush) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_hit[k]) begin
          value_q[cdb_tag_k[k]] <= cdb_result[k*32 +: 32];
        end
      end
      if (issue_fire) begin
        value_q[tail_q]  <= '0;
        kind_q[tail_q]   <= issue_kind_n;
        rd_q[tail_q]     <= issue_rd;
        pc_q[tail_q]     <= issue_pc;
        alt_pc_q[tail_q] <= issue_alt;
        pred_q[tail_q]   <= issue_predict;
      end
    end
  end

  assign rob_next_tag   = tail_q;
  assign rob_top_tag    = head_q;
  assign rob_count      = count_q;
  assign rob_full       = (count_q >= FullThresh);
  assign commit_valid   = commit_valid_q;
  assign commit_rd      = commit_rd_q;
  assign commit_tag     = commit_tag_q;
  assign commit_val     = commit_val_q;
  assign commit_store   = commit_store_q;
  assign pred_upd_valid = pred_upd_valid_q;
  assign pred_upd_pc    = pred_upd_pc_q;
  assign pred_upd_taken = pred_upd_taken_q;
  assign rollback       = rollback_q;
  assign reset_pc       = reset_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit at DEPTH=4: queue-based reference model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_rob_multi_commit;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned TAG_W       = 2;
  localparam int unsigned NUM_CDB     = 2;
  localparam int unsigned COMMIT_W    = 2;
  localparam int unsigned FULL_MARGIN = 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      rdy;
  logic                      issue_valid;
  logic [1:0]                issue_kind;
  logic [4:0]                issue_rd;
  logic [31:0]               issue_pc;
  logic [31:0]               issue_imm;
  logic                      issue_predict;
  logic [TAG_W-1:0]          rob_next_tag;
  logic [TAG_W-1:0]          rob_top_tag;
  logic                      rob_full;
  logic [TAG_W:0]            rob_count;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*32-1:0]     cdb_result;
  logic [COMMIT_W-1:0]       commit_valid;
  logic [COMMIT_W*5-1:0]     commit_rd;
  logic [COMMIT_W*TAG_W-1:0] commit_tag;
  logic [COMMIT_W*32-1:0]    commit_val;
  logic                      commit_store;
  logic                      pred_upd_valid;
  logic [31:0]               pred_upd_pc;
  logic                      pred_upd_taken;
  logic                      rollback;
  logic [31:0]               reset_pc;

  always #5 clk = ~clk;

  rob_multi_commit #(
    .DEPTH      (DEPTH),
    .TAG_W      (TAG_W),
    .NUM_CDB    (NUM_CDB),
    .COMMIT_W   (COMMIT_W),
    .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .issue_valid   (issue_valid),
    .issue_kind    (issue_kind),
    .issue_rd      (issue_rd),
    .issue_pc      (issue_pc),
    .issue_imm     (issue_imm),
    .issue_predict (issue_predict),
    .rob_next_tag  (rob_next_tag),
    .rob_top_tag   (rob_top_tag),
    .rob_full      (rob_full),
    .rob_count     (rob_count),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_result    (cdb_result),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_tag    (commit_tag),
    .commit_val    (commit_val),
    .commit_store  (commit_store),
    .pred_upd_valid(pred_upd_valid),
    .pred_upd_pc   (pred_upd_pc),
    .pred_upd_taken(pred_upd_taken),
    .rollback      (rollback),
    .reset_pc      (reset_pc)
  );

  // Reference model: program-order queue of in-flight instructions, oldest first.
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        ready;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  int          head_tag;
  logic [1:0]  e_cv;
  logic [4:0]  e_rd  [2];
  int          e_tag [2];
  logic [31:0] e_val [2];
  logic        e_store, e_pv, e_ptaken, e_rb;
  logic [31:0] e_ppc, e_rpc;
  int          vectors = 0;
  int          miscompares = 0;
  int          protocol_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    head_tag = 0;
    e_cv     = '0;
    e_store  = 1'b0;
    e_pv     = 1'b0;
    e_rb     = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    int   n;
    int   off;
    ent_t e;
    e_cv    = '0;
    e_store = 1'b0;
    e_pv    = 1'b0;
    if (e_rb) begin
      e_rb = 1'b0;
      q.delete();
      head_tag = 0;
      return;
    end
    if (!rdy) return;
    n = 0;
    if (q.size() > 0 && q[0].ready) n = 1;
    if (n == 1 && q[0].kind == 2'd0 && q.size() >= 2 && q[1].ready) n = 2;
    for (int s = 0; s < n; s++) begin
      e_cv[s]  = 1'b1;
      e_rd[s]  = q[s].rd;
      e_tag[s] = (head_tag + s) % DEPTH;
      e_val[s] = q[s].val;
      if (q[s].kind == 2'd1) e_store = 1'b1;
      if (q[s].kind == 2'd2) begin
        e_pv     = 1'b1;
        e_ppc    = q[s].pc;
        e_ptaken = q[s].val[0];
        if (q[s].val[0] != q[s].pred) begin
          e_rb  = 1'b1;
          e_rpc = q[s].pc + (q[s].pred ? 32'd4 : q[s].imm);
        end
      end
    end
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k]) begin
        off = (int'(cdb_tag[k*TAG_W +: TAG_W]) - head_tag + DEPTH) % DEPTH;
        if (off < q.size()) begin
          e       = q[off];
          e.ready = 1'b1;
          e.val   = cdb_result[k*32 +: 32];
          q[off]  = e;
        end
      end
    end
    for (int s = 0; s < n; s++) void'(q.pop_front());
    head_tag = (head_tag + n) % DEPTH;
    if (issue_valid) begin
      if (q.size() < DEPTH) begin
        e.kind  = (issue_kind == 2'd3) ? 2'd0 : issue_kind;
        e.rd    = issue_rd;
        e.pc    = issue_pc;
        e.imm   = issue_imm;
        e.pred  = issue_predict;
        e.ready = (e.kind != 2'd2) && (issue_rd == 5'd0);
        e.val   = '0;
        q.push_back(e);
      end else begin
        protocol_errors++;
        $display("protocol error: issue while ROB holds %0d entries was dropped (t=%0t)",
                 q.size(), $time);
      end
    end
  endtask

  task automatic check_all();
    chk("rob_count", 32'(rob_count), 32'(q.size()));
    chk("rob_top_tag", 32'(rob_top_tag), 32'(head_tag));
    chk("rob_next_tag", 32'(rob_next_tag), 32'((head_tag + q.size()) % DEPTH));
    chk("rob_full", 32'(rob_full), 32'(q.size() >= DEPTH - FULL_MARGIN));
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    for (int s = 0; s < COMMIT_W; s++) begin
      if (e_cv[s]) begin
        chk($sformatf("commit_rd[%0d]", s), 32'(commit_rd[s*5 +: 5]), 32'(e_rd[s]));
        chk($sformatf("commit_tag[%0d]", s), 32'(commit_tag[s*TAG_W +: TAG_W]), 32'(e_tag[s]));
        chk($sformatf("commit_val[%0d]", s), commit_val[s*32 +: 32], e_val[s]);
      end
    end
    chk("commit_store", 32'(commit_store), 32'(e_store));
    chk("pred_upd_valid", 32'(pred_upd_valid), 32'(e_pv));
    if (e_pv) begin
      chk("pred_upd_pc", pred_upd_pc, e_ppc);
      chk("pred_upd_taken", 32'(pred_upd_taken), 32'(e_ptaken));
    end
    chk("rollback", 32'(rollback), 32'(e_rb));
    if (e_rb) chk("reset_pc", reset_pc, e_rpc);
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_kind    = '0;
    issue_rd      = '0;
    issue_pc      = '0;
    issue_imm     = '0;
    issue_predict = 1'b0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_result    = '0;
  endtask

  task automatic iss(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                     input logic [31:0] imm, input logic pred);
    issue_valid   = 1'b1;
    issue_kind    = kind;
    issue_rd      = rd;
    issue_pc      = pc;
    issue_imm     = imm;
    issue_predict = pred;
  endtask

  task automatic cdb(input int port, input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid[port]               = 1'b1;
    cdb_tag[port*TAG_W +: TAG_W]  = tag;
    cdb_result[port*32 +: 32]     = val;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  int exp_tags [3] = '{3, 0, 1};

  initial begin
    rst_n = 1'b1;
    rdy   = 1'b1;
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_count", 32'(rob_count), 32'd0);
    chk("reset_rollback", 32'(rollback), 32'd0);
    chk("reset_reset_pc", reset_pc, 32'd0);
    chk("reset_commit_valid", 32'(commit_valid), 32'd0);
    chk("reset_next_tag", 32'(rob_next_tag), 32'd0);
    #10 rst_n = 1'b1;

    // Reset mid-fill; the fifth issue hits a full buffer.
    for (int i = 1; i <= 5; i++) begin
      iss(2'd0, 5'(i), 32'h1000 + 32'(4 * i), 32'd0, 1'b0);
      cycle();
    end
    chk("fill_count", 32'(rob_count), 32'd4);
    chk("fill_full", 32'(rob_full), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(rob_count), 32'd0);
    chk("async_rollback", 32'(rollback), 32'd0);
    chk("async_commit_valid", 32'(commit_valid), 32'd0);
    chk("async_full", 32'(rob_full), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;

    // Dual commit; kind 3 behaves as a register writer so slot 1 may follow it.
    iss(2'd3, 5'd3, 32'h10, 32'd0, 1'b0); cycle();
    iss(2'd0, 5'd4, 32'h14, 32'd0, 1'b0); cycle();
    cdb(0, 2'd0, 32'h11); cdb(1, 2'd1, 32'h22); cycle();
    rdy = 1'b0; cycle();
    rdy = 1'b1; cycle();
    chk("dual_valid", 32'(commit_valid), 32'h3);
    chk("dual_rd0", 32'(commit_rd[4:0]), 32'd3);
    chk("dual_rd1", 32'(commit_rd[9:5]), 32'd4);
    chk("dual_val0", commit_val[31:0], 32'h11);
    chk("dual_val1", commit_val[63:32], 32'h22);
    rdy = 1'b0; cycle();
    rdy = 1'b1;

    // Store ordering: the store retires alone, the ready rd=0 entry follows next cycle.
    iss(2'd1, 5'd1, 32'h20, 32'd0, 1'b0); cycle();
    iss(2'd0, 5'd0, 32'h24, 32'd0, 1'b0); cycle();
    iss(2'd0, 5'd5, 32'h28, 32'd0, 1'b0); cycle();
    cdb(0, 2'd2, 32'hdead); cycle();
    cycle();
    chk("store_valid", 32'(commit_valid), 32'h1);
    chk("store_strobe", 32'(commit_store), 32'd1);
    chk("store_tag", 32'(commit_tag[1:0]), 32'd2);
    cycle();
    chk("after_store_valid", 32'(commit_valid), 32'h1);
    chk("after_store_tag", 32'(commit_tag[1:0]), 32'd3);
    chk("after_store_strobe", 32'(commit_store), 32'd0);
    cdb(1, 2'd0, 32'h55); cycle();
    cycle();
    chk("rd5_val", commit_val[31:0], 32'h55);

    // Mispredict: not-taken prediction, branch taken.
    iss(2'd2, 5'd0, 32'h100, 32'h40, 1'b0); cycle();
    cdb(0, 2'd1, 32'd1); cycle();
    cycle();
    chk("mp_pred_valid", 32'(pred_upd_valid), 32'd1);
    chk("mp_pred_taken", 32'(pred_upd_taken), 32'd1);
    chk("mp_pred_pc", pred_upd_pc, 32'h100);
    chk("mp_rollback", 32'(rollback), 32'd1);
    chk("mp_reset_pc", reset_pc, 32'h140);
    iss(2'd0, 5'd0, 32'h500, 32'd0, 1'b0); cdb(0, 2'd2, 32'h9); cycle();
    chk("mp_flush_count", 32'(rob_count), 32'd0);
    chk("mp_flush_rollback", 32'(rollback), 32'd0);
    chk("mp_flush_next_tag", 32'(rob_next_tag), 32'd0);

    // Correctly predicted taken branch: update but no rollback.
    iss(2'd2, 5'd0, 32'h200, 32'h10, 1'b1); cycle();
    cdb(1, 2'd0, 32'd1); cycle();
    cycle();
    chk("ok_pred_valid", 32'(pred_upd_valid), 32'd1);
    chk("ok_rollback", 32'(rollback), 32'd0);
    cycle();

    // Predicted taken, actually not taken: redirect to pc+4.
    iss(2'd2, 5'd0, 32'h300, 32'h80, 1'b1); cycle();
    cdb(0, 2'd1, 32'd0); cycle();
    cycle();
    chk("nt_rollback", 32'(rollback), 32'd1);
    chk("nt_reset_pc", reset_pc, 32'h304);
    chk("nt_pred_taken", 32'(pred_upd_taken), 32'd0);
    cycle();

    // Full / wrap.
    iss(2'd0, 5'd1, 32'h40, 32'd0, 1'b0); cycle();
    iss(2'd0, 5'd2, 32'h44, 32'd0, 1'b0); cycle();
    iss(2'd0, 5'd3, 32'h48, 32'd0, 1'b0); cycle();
    chk("wrap_full3", 32'(rob_full), 32'd1);
    cdb(0, 2'd0, 32'h10); cdb(1, 2'd1, 32'h20); cycle();
    cycle();
    chk("wrap_retire2", 32'(commit_valid), 32'h3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_tag%0d", i), 32'(rob_next_tag), 32'(exp_tags[i]));
      iss(2'd0, 5'(10 + i), 32'h60 + 32'(4 * i), 32'd0, 1'b0); cycle();
    end
    chk("wrap_count4", 32'(rob_count), 32'd4);
    chk("wrap_next2", 32'(rob_next_tag), 32'd2);
    iss(2'd0, 5'd20, 32'h70, 32'd0, 1'b0); cycle();
    chk("drop_count", 32'(rob_count), 32'd4);

    // CDB collision on tag 2, then retire while issuing at full occupancy.
    cdb(0, 2'd2, 32'hAA); cdb(1, 2'd2, 32'hBB); cycle();
    iss(2'd0, 5'd21, 32'h74, 32'd0, 1'b0); cycle();
    chk("collide_val", commit_val[31:0], 32'hBB);
    chk("full_swap_count", 32'(rob_count), 32'd4);
    chk("full_swap_next", 32'(rob_next_tag), 32'd3);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
